opb_register_simulink2ppc: RTL

Read-back register from user fabric logic to the PowerPC over OPB: the return path for the PPC-to-fabric control registers.
- Fabric side presents a 32-bit word with a valid strobe.
- Block snapshots the word, tracks freshness, overrun and an update count, and serves both on a two-word OPB slave window.
- Used for gain/status readback, e.g. quantiser saturation counts, beside the existing EQ gain control registers.

---
 rtl/roach_opb_pkg.sv | 19 +
 rtl/opb_slave_ack.sv | 82 ++++++++
 rtl/opb_register_simulink2ppc.sv | 114 +++++++++++
 3 files changed

// File: rtl/roach_opb_pkg.sv
// Shared OPB slave definitions: register offsets, status bit positions (bus numbering, bit 0 = MSB)
// and the transfer FSM encoding.
package roach_opb_pkg;

  localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;

  localparam int STAT_FRESH   = 31;
  localparam int STAT_OVR     = 30;
  localparam int STAT_CNT_MSB = 0;
  localparam int STAT_CNT_LSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACK    = 2'd2
  } opb_state_e;

endpackage

// File: rtl/opb_slave_ack.sv
// OPB slave handshake: window decode, IDLE/DECODE/ACK sequencing and a one-cycle post-ack guard.
// Ack lands two cycles after select is first seen; a select dropped during DECODE aborts silently.
module opb_slave_ack
  import roach_opb_pkg::*;
#(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_0F00,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_0FFF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [0:C_OPB_AWIDTH-1] abus_i,
  input  logic                    select_i,
  input  logic                    rnw_i,
  output logic                    load_o,
  output logic                    ack_o,
  output logic                    rnw_o,
  output logic [C_OPB_AWIDTH-1:0] ofs_o
);

  opb_state_e              state_q, state_d;
  logic                    ack_dly_q, ack_dly_d;
  logic                    rnw_q, rnw_d;
  logic [C_OPB_AWIDTH-1:0] ofs_q, ofs_d;
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] addr_ofs;
  logic                    hit;

  assign addr     = abus_i;
  assign addr_ofs = addr - C_BASEADDR;
  // A master still holding select right after its ack must not start a second transfer.
  assign hit      = select_i && !ack_dly_q && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  always_comb begin
    state_d   = state_q;
    ofs_d     = ofs_q;
    rnw_d     = rnw_q;
    ack_dly_d = (state_q == ST_ACK);
    load_o    = 1'b0;
    ack_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_DECODE;
          ofs_d   = addr_ofs & {{(C_OPB_AWIDTH-2){1'b1}}, 2'b00};
          rnw_d   = rnw_i;
        end
      end
      ST_DECODE: begin
        if (select_i) begin
          state_d = ST_ACK;
          load_o  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        ack_o   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ack_dly_q <= 1'b0;
      rnw_q     <= 1'b0;
      ofs_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_dly_q <= ack_dly_d;
      rnw_q     <= rnw_d;
      ofs_q     <= ofs_d;
    end
  end

  assign rnw_o = rnw_q;
  assign ofs_o = ofs_q;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PPC readback register: snapshots a user word and serves DATA/STATUS on a two-word OPB window.
// Reads see the value at entry to ACK; a DATA-read ack clears fresh unless a new word lands that cycle.
module opb_register_simulink2ppc
  import roach_opb_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0F00,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_0FFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid
);

  localparam int unused_family_bits = $bits(C_FAMILY);

  logic                    load, ack, rnw;
  logic [C_OPB_AWIDTH-1:0] ofs;
  logic                    sel_data, sel_status, rd_data_ack, wr_stat_ack;
  logic [31:0]             data_q, data_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    fresh_q, fresh_d, ovr_q, ovr_d;
  logic [0:C_OPB_DWIDTH-1] rdata_q, rdata_d;
  logic [0:31]             status_w;
  logic                    unused_in;

  opb_slave_ack #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR)
  ) u_ack (
    .clk_i    (OPB_Clk),
    .rst_i    (OPB_Rst),
    .abus_i   (OPB_ABus),
    .select_i (OPB_select),
    .rnw_i    (OPB_RNW),
    .load_o   (load),
    .ack_o    (ack),
    .rnw_o    (rnw),
    .ofs_o    (ofs)
  );

  assign sel_data    = (ofs == C_OPB_AWIDTH'(OFS_DATA));
  assign sel_status  = (ofs == C_OPB_AWIDTH'(OFS_STATUS));
  assign rd_data_ack = ack && rnw && sel_data;
  assign wr_stat_ack = ack && !rnw && sel_status;

  always_comb begin
    status_w                           = '0;
    status_w[STAT_CNT_MSB:STAT_CNT_LSB] = cnt_q;
    status_w[STAT_OVR]                 = ovr_q;
    status_w[STAT_FRESH]               = fresh_q;
  end

  always_comb begin
    rdata_d = '0;
    if (load && rnw) begin
      if (sel_data)        rdata_d = data_q;
      else if (sel_status) rdata_d = status_w;
    end
  end

  // A status write clears first, so a same-cycle capture still counts as the first new word.
  always_comb begin
    data_d  = user_data_valid ? user_data_in : data_q;
    cnt_d   = wr_stat_ack ? 16'd0 : cnt_q;
    fresh_d = fresh_q;
    ovr_d   = wr_stat_ack ? 1'b0 : ovr_q;
    if (wr_stat_ack || rd_data_ack) fresh_d = 1'b0;
    if (user_data_valid) begin
      cnt_d   = cnt_d + 16'd1;
      fresh_d = 1'b1;
      if (fresh_q && !rd_data_ack && !wr_stat_ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      fresh_q <= 1'b0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

  assign unused_in  = ^{OPB_BE, OPB_DBus, OPB_seqAddr};
  assign Sl_DBus    = rdata_q;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
